// File: rtl/mem_bus_pkg.sv
// Shared constants and loader state encoding for the adding-machine memory side.
package mem_bus_pkg;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;
endpackage

// File: rtl/mem_loader.sv
// Byte-stream program loader: fills memory from address 0 while holding the CPU in reset.
module mem_loader
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_bus_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_bus_pkg::DATA_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              cpu_hold,
  output logic              ld_we,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data
);

  load_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              at_end;

  assign accept  = (state == LOAD) && load_valid;
  assign at_end  = (cnt == ADDR_W'(DEPTH - 1));
  assign ld_we   = accept;
  assign ld_addr = cnt;
  assign ld_data = load_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // The counter saturates at the last word instead of wrapping back to 0.
      if (state == IDLE && load_start)
        cnt <= '0;
      else if (accept && !at_end)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    load_done  = 1'b0;
    cpu_hold   = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_nxt = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (accept && (load_last || at_end)) state_nxt = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        cpu_hold  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// 64x8 memory responder for the CPU bus with an integrated program loader.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_bus_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_bus_pkg::DATA_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr_bus,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              cpu_hold,
  output logic              bus_err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              cpu_rd;
  logic              cpu_wr;

  mem_loader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_loader (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .load_done (load_done),
    .cpu_hold  (cpu_hold),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  // CPU strobes only count while the loader is idle; a read wins over a clashing write.
  assign cpu_rd = !cpu_hold && rd_mem;
  assign cpu_wr = !cpu_hold && wr_mem && !rd_mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end else if (cpu_wr) begin
      mem[adr_bus] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (cpu_rd) mem_rdata <= mem[adr_bus];
      if (cpu_rd && wr_mem) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: reads push expected data, a monitor checks responses.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] adr_bus;
  logic       rd_mem, wr_mem;
  logic [7:0] mem_wdata, mem_rdata;
  logic       load_start, load_valid, load_last;
  logic [7:0] load_data;
  logic       load_ready, load_done, cpu_hold, bus_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  logic [7:0] exp_q[$];
  bit rd_issued;

  mem_responder #(.ADDR_W(6), .DATA_W(8), .DEPTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .adr_bus   (adr_bus),
    .rd_mem    (rd_mem),
    .wr_mem    (wr_mem),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .load_done (load_done),
    .cpu_hold  (cpu_hold),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Read-data monitor: one response per cycle the bench held rd_mem high.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      rd_issued = rd_mem && !reset;
      @(negedge clk);
      if (rd_issued) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rdata_unexpected got %0h expected none", mem_rdata);
        end else begin
          e = exp_q.pop_front();
          if (mem_rdata !== e) begin
            errors++;
            $display("FAIL rdata got %0h expected %0h", mem_rdata, e);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (load_done === 1'b1) done_cnt++;
      if (load_valid === 1'b1 && load_ready === 1'b1) acc_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    adr_bus = a; mem_wdata = d; wr_mem = 1'b1;
    tick();
    wr_mem = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [7:0] e);
    adr_bus = a; rd_mem = 1'b1;
    exp_q.push_back(e);
    tick();
    exp_q.push_back(e);
    tick();
    rd_mem = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    check("hold_in_load", 32'(cpu_hold), 32'd1);
  endtask

  initial begin
    int d0, a0;
    reset = 1'b1; adr_bus = '0; rd_mem = 0; wr_mem = 0; mem_wdata = '0;
    load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_rdata", 32'(mem_rdata), 32'h00);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_buserr", 32'(bus_err), 32'd0);
    do_read(6'h15, 8'h00);
    check("buserr_after_read", 32'(bus_err), 32'd0);

    // CPU write then read, data held after rd_mem drops
    do_write(6'h0A, 8'hA5);
    do_read(6'h0A, 8'hA5);
    tick();
    check("rdata_hold", 32'(mem_rdata), 32'hA5);

    // Short load with an idle gap
    d0 = done_cnt;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_ready_up", 32'(load_ready), 32'd1);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    tick();
    check("hold_gap", 32'(cpu_hold), 32'd1);
    send(8'h33, 1'b1);
    check("done_pulse", 32'(load_done), 32'd1);
    check("ready_in_done", 32'(load_ready), 32'd0);
    tick();
    check("hold_released", 32'(cpu_hold), 32'd0);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    do_read(6'h00, 8'h11);
    do_read(6'h01, 8'h22);
    do_read(6'h02, 8'h33);
    do_read(6'h03, 8'h00);

    // Simultaneous strobes: read wins, write dropped, sticky error
    adr_bus = 6'h0A; mem_wdata = 8'hFF; rd_mem = 1'b1; wr_mem = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    rd_mem = 1'b0; wr_mem = 1'b0;
    check("buserr_set", 32'(bus_err), 32'd1);
    do_read(6'h0A, 8'hA5);
    check("buserr_sticky", 32'(bus_err), 32'd1);

    // Overlong load: 70 bytes offered, only 64 accepted
    d0 = done_cnt; a0 = acc_cnt;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      load_valid = 1'b1; load_data = 8'(i + 1);
      tick();
      if (i == 63) begin
        check("ready_drop_63", 32'(load_ready), 32'd0);
        check("done_at_63", 32'(load_done), 32'd1);
      end
    end
    load_valid = 1'b0;
    tick();
    check("accepted_64", 32'(acc_cnt - a0), 32'd64);
    check("done_once_full", 32'(done_cnt - d0), 32'd1);
    check("hold_after_full", 32'(cpu_hold), 32'd0);
    do_read(6'h3F, 8'h40);
    do_read(6'h00, 8'h01);
    do_read(6'h0A, 8'h0B);
    do_read(6'h3E, 8'h3F);
    check("buserr_still", 32'(bus_err), 32'd1);

    // Reset mid-load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_hold", 32'(cpu_hold), 32'd0);
    check("midrst_ready", 32'(load_ready), 32'd0);
    check("midrst_buserr", 32'(bus_err), 32'd0);
    check("midrst_rdata", 32'(mem_rdata), 32'h00);
    tick();
    reset = 1'b0;
    tick();
    do_read(6'h00, 8'h00);
    do_read(6'h01, 8'h00);
    do_read(6'h3F, 8'h00);

    tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the adding-machine CPU bus. It is a 64x8 storage array that services the CPU's address, read-strobe, write-strobe and data-out signals, and drives read data back to the CPU's data input.
- It also contains a byte-stream program loader. The loader fills memory from address 0 while holding the CPU in reset, so a bench or tester can preload programs without touching the CPU bus.

Parameters:
- ADDR_W, 6, address width; matches CPU adr_bus.
- DATA_W, 8, data width; matches CPU data buses.
- DEPTH, 64, number of words; always equals 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- adr_bus  in  ADDR_W  word address from CPU.
- rd_mem  in  1  CPU read strobe.
- wr_mem  in  1  CPU write strobe.
- mem_wdata  in  DATA_W  write data; connects to CPU data_bus_out.
- mem_rdata  out  DATA_W  read data; connects to CPU data_bus_in.
- load_start  in  1  one-cycle pulse that starts a program load.
- load_valid  in  1  load byte present.
- load_data  in  DATA_W  load byte.
- load_last  in  1  marks the final byte of a load, qualified by load_valid.
- load_ready  out  1  loader accepts a byte this cycle.
- load_done  out  1  one-cycle pulse when a load completes.
- cpu_hold  out  1  holds the CPU in reset; OR-ed into CPU reset at the top level.
- bus_err  out  1  sticky flag for rd_mem and wr_mem asserted together.

Behaviour:
- Reset, asynchronous:
  - Every array word = 0.
  - mem_rdata = 0, load_ready = 0, load_done = 0, cpu_hold = 0, bus_err = 0.
  - Loader FSM = IDLE, load address counter = 0.
  - Reset asserted mid-load aborts the load immediately; the partial contents are cleared to 0.
- CPU write (FSM in IDLE):
  - wr_mem=1 and rd_mem=0: mem[adr_bus] <= mem_wdata at the clock edge.
  - The written value is readable on the next cycle.
- CPU read (FSM in IDLE):
  - rd_mem=1: mem_rdata <= mem[adr_bus] at the clock edge. Latency is 1 cycle.
  - mem_rdata holds its last value while rd_mem=0.
  - The controller therefore keeps rd_mem asserted for 2 cycles per fetch.
- Read during write to the same address in the same cycle cannot occur; simultaneous strobes are handled as below.
- rd_mem=1 and wr_mem=1 together:
  - The read is performed and the write is suppressed.
  - bus_err sets and stays set until reset.
- Loader FSM, states IDLE, LOAD, DONE:
  - IDLE -> LOAD on load_start. Counter <= 0.
  - load_start outside IDLE is ignored.
  - LOAD: load_ready = 1 and cpu_hold = 1. CPU strobes are ignored: no writes, mem_rdata not updated, bus_err not updated.
  - In LOAD, each cycle with load_valid=1 writes mem[counter] <= load_data and increments the counter.
  - LOAD -> DONE when an accepted byte has load_last=1, or when the counter equals DEPTH-1. The counter never wraps; a byte past address 63 is never accepted.
  - DONE lasts 1 cycle: load_done = 1, cpu_hold = 1, load_ready = 0. Then DONE -> IDLE.
  - cpu_hold falls on entry to IDLE, so the CPU leaves reset one cycle after the load_done pulse.
- Words not written by a load keep their prior contents.

Decomposition:
- Shared package mem_bus_pkg holds:
  - ADDR_W, DATA_W, DEPTH constants.
  - Loader state enum (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
- One natural sub-module, mem_loader. It contains the FSM, counter, load_ready, load_done and cpu_hold, and outputs a write-enable/address/data triple.
- The top module muxes the loader write triple over the CPU write path and owns the array and bus_err.

Test Plan:
- Reset, then rd_mem=1 at adr=6'h15 for 2 cycles -> mem_rdata=8'h00; bus_err=0; cpu_hold=0.
- wr_mem=1 at adr=6'h0A with mem_wdata=8'hA5, next cycle rd_mem=1 at adr=6'h0A -> mem_rdata=8'hA5 one cycle after rd_mem rises; held after rd_mem drops.
- load_start, then bytes 8'h11, 8'h22, 8'h33 with load_last on 8'h33 (one idle-valid gap inserted) -> cpu_hold high throughout; load_done pulses once; then reads at 0/1/2 return 8'h11/8'h22/8'h33 and address 3 is unchanged.
- load_start, then 70 continuous valid bytes with no load_last -> exactly 64 accepted; load_ready drops after the byte at address 63; mem[63] = 64th byte; mem[0] is not overwritten.
- rd_mem=1 and wr_mem=1 together at adr=6'h0A with mem_wdata=8'hFF (mem[0x0A]=8'hA5) -> mem_rdata=8'hA5; mem unchanged; bus_err=1 and stays 1 until reset.
- Reset asserted mid-load after 2 bytes -> FSM back in IDLE; cpu_hold=0 and load_ready=0 immediately; mem[0]=mem[1]=0.
